// File: rtl/cache_controller.sv
// Data-cache controller for the MEM stage: 2-way set-associative, write-through,
// no-write-allocate, sitting between the MEM stage and the SRAM controller.
module cache_controller #(
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned IdxW = $clog2(SETS);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e state_q;

  logic [SETS-1:0]  valid_q [2];
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [63:0]      line_q  [2][SETS];
  logic [SETS-1:0]  lru_q;

  logic [IdxW-1:0]  idx;
  logic [TAG_W-1:0] addr_tag;
  logic             word_sel;
  logic             hit0, hit1, hit, hit_way, victim;
  logic             wr_req, rd_req;
  logic [63:0]      hit_line;
  logic [31:0]      hit_word, fill_word;

  assign word_sel = address[2];
  assign idx      = address[3 +: IdxW];
  assign addr_tag = address[3 + IdxW +: TAG_W];

  // Stores win over loads when both enables are raised.
  assign wr_req = MEM_W_EN;
  assign rd_req = MEM_R_EN && !MEM_W_EN;

  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == addr_tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == addr_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;

  assign hit_line  = line_q[hit_way][idx];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

  // Prefer an empty way; only fall back on LRU when the set is full.
  always_comb begin
    victim = lru_q[idx];
    if (!valid_q[0][idx]) begin
      victim = 1'b0;
    end else if (!valid_q[1][idx]) begin
      victim = 1'b1;
    end
  end

  assign sram_address = MEM_W_EN ? address : {address[31:3], 3'b000};
  assign sram_wdata   = wdata;

  always_comb begin
    ready = 1'b1;
    rdata = hit ? hit_word : 32'd0;
    case (state_q)
      StIdle:  ready = !(wr_req || (rd_req && !hit));
      StRead: begin
        ready = sram_ready;
        rdata = fill_word;
      end
      StWrite: ready = sram_ready;
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sram_r_en <= 1'b0;
      sram_w_en <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wr_req) begin
            state_q   <= StWrite;
            sram_w_en <= 1'b1;
          end else if (rd_req && !hit) begin
            state_q   <= StRead;
            sram_r_en <= 1'b1;
          end
        end
        StRead: begin
          if (sram_ready) begin
            state_q   <= StIdle;
            sram_r_en <= 1'b0;
          end
        end
        StWrite: begin
          if (sram_ready) begin
            state_q   <= StIdle;
            sram_w_en <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          sram_r_en <= 1'b0;
          sram_w_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (state_q == StIdle && hit && (wr_req || rd_req)) begin
      lru_q[idx] <= !hit_way;
    end else if (state_q == StRead && sram_ready) begin
      valid_q[victim][idx] <= 1'b1;
      lru_q[idx]           <= !victim;
    end
  end

  // Tag and line storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StIdle && wr_req && hit) begin
      if (word_sel) begin
        line_q[hit_way][idx][63:32] <= wdata;
      end else begin
        line_q[hit_way][idx][31:0] <= wdata;
      end
    end else if (!rst && state_q == StRead && sram_ready) begin
      tag_q[victim][idx]  <= addr_tag;
      line_q[victim][idx] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random traffic
// checked against a set/way/LRU reference model and a word-addressed SRAM model.
module tb_cache_controller;

  localparam int L = 5;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_r_en, sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int checks = 0;
  int errors = 0;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing store and cache reference state.
  logic [31:0] mem [logic [16:0]];
  bit          m_valid [2][64];
  int          m_tag   [2][64];
  logic [31:0] m_data  [2][64][2];
  int          m_lru   [64];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [16:0] k;
    k = a[18:2];
    if (mem.exists(k)) return mem[k];
    return 32'h5A00_0000 ^ {15'd0, k} ^ ({15'd0, k} << 13);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < 64; s++) m_lru[s] = 0;
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] exp_rd, output int exp_st);
    int s, t, ws, way, v;
    s   = int'((a >> 3) % 32'd64);
    t   = int'((a >> 9) % 32'd1024);
    ws  = int'((a >> 2) % 32'd2);
    way = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][s] && m_tag[w][s] == t) way = w;
    exp_rd = '0;
    if (wr) begin
      exp_st = L;
      if (way >= 0) begin
        m_data[way][s][ws] = wd;
        m_lru[s] = 1 - way;
      end
      mem[a[18:2]] = wd;
    end else if (way >= 0) begin
      exp_st   = 0;
      exp_rd   = m_data[way][s][ws];
      m_lru[s] = 1 - way;
    end else begin
      exp_st = L;
      v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : m_lru[s]);
      m_valid[v][s]   = 1'b1;
      m_tag[v][s]     = t;
      m_data[v][s][0] = mem_rd({a[31:3], 3'b000});
      m_data[v][s][1] = mem_rd({a[31:3], 3'b100});
      m_lru[s]        = 1 - v;
      exp_rd          = m_data[v][s][ws];
    end
  endtask

  // Plays the MEM stage and an SRAM controller of latency L for one request.
  // perr counts protocol violations seen on the SRAM side, plus a timeout.
  task automatic drive(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [63:0] line, output logic [31:0] got_rd,
                       output int stalls, output int perr);
    int en_cnt;
    bit done;
    logic [31:0] exp_sa;
    en_cnt = 0; done = 0; stalls = 0; perr = 0; got_rd = '0;
    exp_sa = wr ? a : {a[31:3], 3'b000};
    @(posedge clk); #1;
    MEM_R_EN = !wr; MEM_W_EN = wr; address = a; wdata = wd;
    sram_rdata = line; sram_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      #1;
      if (sram_r_en && sram_w_en) perr++;
      if (cyc == 0 && (sram_r_en || sram_w_en)) perr++;
      if (cyc > 0 && (sram_r_en !== !wr || sram_w_en !== wr)) perr++;
      if (sram_address !== exp_sa || sram_wdata !== wd) perr++;
      if (sram_r_en || sram_w_en) en_cnt++;
      if (en_cnt == L) sram_ready = 1'b1;
      @(negedge clk);
      if (ready === 1'b1) begin
        done   = 1;
        got_rd = rdata;
      end else begin
        stalls++;
      end
    end
    if (!done) perr++;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] got_rd, output int got_st,
                      output logic [31:0] exp_rd, output int exp_st, output int perr);
    logic [63:0] line;
    line = {mem_rd({a[31:3], 3'b100}), mem_rd({a[31:3], 3'b000})};
    model_access(wr, a, wd, exp_rd, exp_st);
    drive(wr, a, wd, line, got_rd, got_st, perr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] g, e;
    int gs, es, pe;
    do_reset();
    address = 32'h0; wdata = 32'h0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || sram_r_en !== 1'b0 || sram_w_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b r_en=%b w_en=%b, want 1 0 0", ready, sram_r_en,
               sram_w_en);
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    xfer(1'b0, 32'h0000_0400, 32'h0, g, gs, e, es, pe);
    checks++;
    if (gs !== L || pe !== 0) begin
      errors++;
      $display("FAIL reset_first_read_miss: stalls=%0d perr=%0d want %0d 0", gs, pe, L);
    end
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] g, e;
    int gs, es, pe;
    do_reset();
    mem[17'h100] = 32'hAAAA_AAAA;
    mem[17'h101] = 32'hBBBB_BBBB;
    xfer(1'b0, 32'h0000_0404, 32'h0, g, gs, e, es, pe);
    checks++;
    if (gs !== 5 || g !== 32'hBBBB_BBBB || pe !== 0) begin
      errors++;
      $display("FAIL read_miss: stalls=%0d rdata=%h perr=%0d want 5 bbbbbbbb 0", gs, g, pe);
    end
    xfer(1'b0, 32'h0000_0400, 32'h0, g, gs, e, es, pe);
    checks++;
    if (gs !== 0 || g !== 32'hAAAA_AAAA || pe !== 0) begin
      errors++;
      $display("FAIL read_hit: stalls=%0d rdata=%h perr=%0d want 0 aaaaaaaa 0", gs, g, pe);
    end
  endtask

  task automatic test_lru_evict();
    logic [31:0] addrs [5];
    int want_st [5];
    logic [31:0] g, e;
    int gs, es, pe;
    addrs = '{32'h0400, 32'h8400, 32'h1_0400, 32'h8400, 32'h0400};
    want_st = '{L, L, L, 0, L};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, addrs[i], 32'h0, g, gs, e, es, pe);
      checks++;
      if (gs !== want_st[i] || gs !== es || g !== e || pe !== 0) begin
        errors++;
        $display("FAIL lru_evict[%0d] addr %h: stalls=%0d rdata=%h perr=%0d want %0d %h 0",
                 i, addrs[i], gs, g, pe, want_st[i], e);
      end
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] g, e;
    int gs, es, pe;
    do_reset();
    xfer(1'b0, 32'h0400, 32'h0, g, gs, e, es, pe);
    xfer(1'b1, 32'h0400, 32'h1234_5678, g, gs, e, es, pe);
    checks++;
    if (gs !== 5 || pe !== 0) begin
      errors++;
      $display("FAIL write_hit_stall: stalls=%0d perr=%0d want 5 0", gs, pe);
    end
    xfer(1'b0, 32'h0400, 32'h0, g, gs, e, es, pe);
    checks++;
    if (gs !== 0 || g !== 32'h1234_5678 || pe !== 0) begin
      errors++;
      $display("FAIL write_hit_update: stalls=%0d rdata=%h want 0 12345678", gs, g);
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] g, e;
    int gs, es, pe;
    do_reset();
    xfer(1'b1, 32'h2000, 32'hDEAD_BEEF, g, gs, e, es, pe);
    checks++;
    if (gs !== 5 || pe !== 0) begin
      errors++;
      $display("FAIL write_miss_stall: stalls=%0d perr=%0d want 5 0", gs, pe);
    end
    xfer(1'b0, 32'h2000, 32'h0, g, gs, e, es, pe);
    checks++;
    if (gs !== 5 || g !== 32'hDEAD_BEEF || pe !== 0) begin
      errors++;
      $display("FAIL write_no_allocate: stalls=%0d rdata=%h want 5 deadbeef", gs, g);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] g, e;
    int gs, es, pe;
    do_reset();
    xfer(1'b0, 32'h0400, 32'h0, g, gs, e, es, pe);
    @(posedge clk); #1;
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = 32'h0C08; sram_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sram_r_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_miss_busy: r_en=%b want 1", sram_r_en);
    end
    @(posedge clk); #1;
    rst = 1'b0; MEM_R_EN = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (sram_r_en !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_miss_abort: r_en=%b ready=%b want 0 1", sram_r_en, ready);
    end
    @(posedge clk); #1;
    sram_ready = 1'b1; sram_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    checks++;
    if (sram_r_en !== 1'b0 || sram_w_en !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL late_sram_ready: r_en=%b w_en=%b ready=%b want 0 0 1", sram_r_en,
               sram_w_en, ready);
    end
    @(posedge clk); #1;
    sram_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL late_fill_discarded: rdata=%h want 0", rdata);
    end
    xfer(1'b0, 32'h0C08, 32'h0, g, gs, e, es, pe);
    checks++;
    if (gs !== L || g !== e || pe !== 0) begin
      errors++;
      $display("FAIL reissue_miss: stalls=%0d rdata=%h want %0d %h", gs, g, L, e);
    end
    xfer(1'b0, 32'h0400, 32'h0, g, gs, e, es, pe);
    checks++;
    if (gs !== L || g !== e || pe !== 0) begin
      errors++;
      $display("FAIL reset_invalidates: stalls=%0d rdata=%h want %0d %h", gs, g, L, e);
    end
  endtask

  // Back-to-back random loads and stores over a few sets and tags.
  task automatic test_random();
    logic [31:0] a, wd, g, e;
    int gs, es, pe;
    bit wr;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      a  = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 2) << 3) | ($urandom_range(0, 1) << 2);
      wr = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      xfer(wr, a, wd, g, gs, e, es, pe);
      checks++;
      if (gs !== es || pe !== 0 || (!wr && g !== e)) begin
        errors++;
        $display("FAIL random[%0d] %s %h: stalls=%0d rdata=%h perr=%0d want %0d %h 0", i,
                 wr ? "st" : "ld", a, gs, g, pe, es, e);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    address = '0; wdata = '0; sram_rdata = '0; sram_ready = 1'b0;
    test_reset();
    test_read_miss_hit();
    test_lru_evict();
    test_write_hit();
    test_write_miss();
    test_reset_mid_miss();
    test_random();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
